shreg194_ctrl: RTL and testbench

Sequencing controller for one 4-bit universal shift register in the 74LS194 style, used in the calculation datapath. It turns a single start/op/count command into the register's mode selects (S1/S0), its serial inputs (SR/SL), its parallel data and its active-low clear, for as many cycles as the command needs. It reports busy and done and captures the last bit shifted out. The register's Q outputs come back into this block, which uses them to generate rotate and arithmetic-shift serial inputs.

---
 rtl/shreg194_pkg.sv | 43 ++++
 rtl/shreg194_serial_mux.sv | 28 ++
 rtl/shreg194_ctrl.sv | 145 ++++++++++++++
 tb/tb_shreg194_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg194_pkg.sv
// Shared types and constants for controllers of a 74LS194-style
// 4-bit universal shift register (op codes, FSM states, mode selects).
package shreg194_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHR   = 3'b010,
        OP_SHL   = 3'b011,
        OP_ROR   = 3'b100,
        OP_ROL   = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic logic is_shift(op_e o);
        return (o == OP_SHR) || (o == OP_SHL) || (o == OP_ROR) ||
               (o == OP_ROL) || (o == OP_ASR);
    endfunction

    // Right shifts move data QA->QD; the bit leaving is QD.
    function automatic logic is_right(op_e o);
        return (o == OP_SHR) || (o == OP_ROR) || (o == OP_ASR);
    endfunction

    function automatic logic [1:0] shift_mode(op_e o);
        return is_right(o) ? MODE_SHR : MODE_SHL;
    endfunction

endpackage

// File: rtl/shreg194_serial_mux.sv
// Serial-input selector for a 194-style register: derives SR/SL from op.
// Ports: op (latched op), sin (fill bit), qa/qd (register ends), sr, sl.
module shreg194_serial_mux
    import shreg194_pkg::*;
(
    input  op_e  op,
    input  logic sin,
    input  logic qa,
    input  logic qd,
    output logic sr,
    output logic sl
);

    always_comb begin
        sr = 1'b0;
        sl = 1'b0;
        unique case (op)
            OP_SHR:  sr = sin;
            OP_ROR:  sr = qd;
            // Sign lives in QA, so ASR re-feeds QA into itself.
            OP_ASR:  sr = qa;
            OP_SHL:  sl = sin;
            OP_ROL:  sl = qa;
            default: ;
        endcase
    end

endmodule

// File: rtl/shreg194_ctrl.sv
// Sequencer turning one start/op/count command into 74LS194 controls.
// Ports: clk, rst (sync, active high), start, op[2:0], count[CNT_W-1:0],
//   din[3:0], sin, q[3:0] (QA..QD feedback) -> s1, s0, sr, sl, pdata[3:0],
//   cr_n, busy, done, last_out.
// Build option: SHREG_CTRL_CLR_EN makes CLEAR pulse cr_n; otherwise CLEAR
//   is a parallel load of 0000 and cr_n stays high.
module shreg194_ctrl
    import shreg194_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [3:0]       din,
    input  logic             sin,
    input  logic [3:0]       q,
    output logic             s1,
    output logic             s0,
    output logic             sr,
    output logic             sl,
    output logic [3:0]       pdata,
    output logic             cr_n,
    output logic             busy,
    output logic             done,
    output logic             last_out
);

    state_e           state;
    op_e              op_q;
    op_e              op_in;
    logic [CNT_W-1:0] rem;

    assign op_in = op_e'(op);

    shreg194_serial_mux u_mux (
        .op  (op_q),
        .sin (sin),
        .qa  (q[0]),
        .qd  (q[3]),
        .sr  (sr),
        .sl  (sl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_HOLD;
            rem      <= '0;
            {s1, s0} <= MODE_HOLD;
            pdata    <= '0;
            cr_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            last_out <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    {s1, s0} <= MODE_HOLD;
                    cr_n     <= 1'b1;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        op_q  <= op_in;
                        pdata <= din;
                        busy  <= 1'b1;
                        unique case (op_in)
                            OP_HOLD: begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                            OP_LOAD: begin
                                state    <= ST_LOAD;
                                {s1, s0} <= MODE_LOAD;
                            end
                            OP_CLEAR: begin
`ifdef SHREG_CTRL_CLR_EN
                                state <= ST_CLEAR;
                                cr_n  <= 1'b0;
`else
                                // Clear realised as a load of zeros.
                                state    <= ST_LOAD;
                                {s1, s0} <= MODE_LOAD;
                                pdata    <= '0;
`endif
                            end
                            default: begin
                                if (count == '0) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state    <= ST_SHIFT;
                                    rem      <= count;
                                    {s1, s0} <= shift_mode(op_in);
                                end
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    state    <= ST_DONE;
                    {s1, s0} <= MODE_HOLD;
                    done     <= 1'b1;
                end

`ifdef SHREG_CTRL_CLR_EN
                ST_CLEAR: begin
                    state <= ST_DONE;
                    cr_n  <= 1'b1;
                    done  <= 1'b1;
                end
`endif

                ST_SHIFT: begin
                    // q is the pre-edge value, i.e. the bit leaving now.
                    last_out <= is_right(op_q) ? q[3] : q[0];
                    rem      <= rem - 1'b1;
                    if (rem == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        {s1, s0} <= MODE_HOLD;
                        done     <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    {s1, s0} <= MODE_HOLD;
                    cr_n     <= 1'b1;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shreg194_ctrl.sv
// Self-checking bench for shreg194_ctrl driving a modelled 74LS194.
// Directed command sequence plus randomized commands vs. reference model.
module tb_shreg194_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [CNT_W-1:0] count = '0;
    logic [3:0]       din = 4'd0;
    logic             sin = 1'b0;
    logic [3:0]       q = 4'd0;
    logic             s1, s0, sr, sl, cr_n, busy, done, last_out;
    logic [3:0]       pdata;

    int errors = 0;
    int checks = 0;
    int mv = 0;
    int lo_exp = 0;

    always #5 clk = ~clk;

    shreg194_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .count    (count),
        .din      (din),
        .sin      (sin),
        .q        (q),
        .s1       (s1),
        .s0       (s0),
        .sr       (sr),
        .sl       (sl),
        .pdata    (pdata),
        .cr_n     (cr_n),
        .busy     (busy),
        .done     (done),
        .last_out (last_out)
    );

    // The controlled 74LS194 (q[0]=QA .. q[3]=QD).
    always @(posedge clk) begin
        if (!cr_n) q <= 4'd0;
        else begin
            case ({s1, s0})
                2'b01: q <= {q[2:0], sr};
                2'b10: q <= {sl, q[3:1]};
                2'b11: q <= pdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit op_right(int o);
        return (o == 2) || (o == 4) || (o == 6);
    endfunction

    function automatic bit op_shift(int o);
        return (o >= 2) && (o <= 6);
    endfunction

    // One shift of a 4-bit value with QA as bit 0.
    function automatic int step(int o, int v, int s);
        case (o)
            2: return ((v << 1) | s) & 15;
            3: return (v >> 1) | (s << 3);
            4: return ((v << 1) | (v >> 3)) & 15;
            5: return (v >> 1) | ((v & 1) << 3);
            6: return ((v << 1) | (v & 1)) & 15;
            default: return v;
        endcase
    endfunction

    function automatic int exp_sr(int o, int v, int s);
        if (o == 2) return s;
        if (o == 4) return (v >> 3) & 1;
        if (o == 6) return v & 1;
        return 0;
    endfunction

    function automatic int exp_sl(int o, int v, int s);
        if (o == 3) return s;
        if (o == 5) return v & 1;
        return 0;
    endfunction

    task automatic run_cmd(input int o, input int n, input int d,
                           input int s, input bit poke);
        int lat, mcyc, bad, bcyc, ccyc, ldat;
        int emode, enm, elat, ecl, eld, vfin;
        bit clr_en;
`ifdef SHREG_CTRL_CLR_EN
        clr_en = 1'b1;
`else
        clr_en = 1'b0;
`endif
        emode = 0; enm = 0; ecl = 0; eld = -1; vfin = mv;
        if (op_shift(o) && n != 0) begin
            emode = op_right(o) ? 1 : 2;
            enm = n;
            for (int i = 0; i < n; i++) begin
                lo_exp = op_right(o) ? ((vfin >> 3) & 1) : (vfin & 1);
                vfin = step(o, vfin, s);
            end
        end else if (o == 1) begin
            emode = 3; enm = 1; eld = d; vfin = d;
        end else if (o == 7) begin
            vfin = 0;
            if (clr_en) ecl = 1;
            else begin emode = 3; enm = 1; eld = 0; end
        end
        if (o == 0 || (op_shift(o) && n == 0)) elat = 1;
        else if (op_shift(o)) elat = n + 1;
        else elat = 2;

        lat = 0; mcyc = 0; bad = 0; bcyc = 0; ccyc = 0; ldat = -1;
        @(negedge clk);
        start = 1'b1; op = o[2:0]; count = n[CNT_W-1:0];
        din = d[3:0]; sin = s[0];
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); din = 4'($urandom);
        count = CNT_W'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcyc++;
            if (!cr_n) ccyc++;
            if ({s1, s0} != 2'b00) begin
                if (int'({s1, s0}) == emode) mcyc++;
                else bad++;
            end
            if ({s1, s0} == 2'b11) ldat = pdata;
            if ({s1, s0} == 2'b01 || {s1, s0} == 2'b10) begin
                check("sr", sr, exp_sr(o, q, s));
                check("sl", sl, exp_sl(o, q, s));
            end
            if (poke && k == 2) begin start = 1'b1; op = 3'd1; end
            if (poke && k == 3) start = 1'b0;
            if (done) begin lat = k; break; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", lat, elat);
        check("busy_cycles", bcyc, elat);
        check("mode_cycles", mcyc, enm);
        check("bad_mode", bad, 0);
        check("clr_cycles", ccyc, ecl);
        if (eld >= 0) check("pdata", ldat, eld);
        check("q", q, vfin);
        check("last_out", last_out, lo_exp);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
        if (poke) begin
            for (int k = 0; k < 4; k++) begin
                check("no_extra_done", done, 0);
                @(posedge clk); #1;
            end
            check("q_after_poke", q, vfin);
        end
        mv = vfin;
    endtask

    task automatic reset_mid(input int o, input int s);
        @(negedge clk);
        start = 1'b1; op = o[2:0]; count = 3'd5; sin = s[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lo_exp = op_right(o) ? ((mv >> 3) & 1) : (mv & 1);
            mv = step(o, mv, s);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        mv = step(o, mv, s);
        lo_exp = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mode", {s1, s0}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last_out", last_out, lo_exp);
        for (int k = 0; k < 4; k++) begin
            check("rst_no_done", done, 0);
            @(posedge clk); #1;
        end
        check("rst_q", q, mv);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mode", {s1, s0}, 0);
        check("reset_pdata", pdata, 0);
        check("reset_cr_n", cr_n, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_last_out", last_out, 0);
        check("reset_sr", sr, 0);
        check("reset_sl", sl, 0);
        rst = 1'b0;

        run_cmd(1, 0, 4'b1011, 0, 1'b0);
        run_cmd(1, 0, 4'b0001, 0, 1'b0);
        run_cmd(2, 2, 0, 0, 1'b0);
        run_cmd(1, 0, 4'b0001, 0, 1'b0);
        run_cmd(5, 1, 0, 0, 1'b0);
        run_cmd(4, 4, 0, 0, 1'b0);
        run_cmd(1, 0, 4'b0001, 0, 1'b0);
        run_cmd(6, 3, 0, 0, 1'b0);
        run_cmd(3, 0, 0, 1, 1'b0);
        run_cmd(1, 0, 4'b0110, 0, 1'b0);
        run_cmd(2, 5, 0, 1, 1'b1);
        run_cmd(1, 0, 4'b1001, 0, 1'b0);
        reset_mid(4, 0);
        run_cmd(1, 0, 4'b1111, 0, 1'b0);
        run_cmd(7, 0, 4'b1010, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
